// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding, default limits and port indices for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic {S_CPU = 1'b0, S_DMA = 1'b1} arb_state_e;
  localparam int MAX_WAIT_DEF  = 4;
  localparam int MAX_BURST_DEF = 8;
  localparam int PORT_CPU      = 0;
  localparam int PORT_DMA      = 1;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-preferred single-port data memory arbiter with DMA anti-starvation and locked bursts
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = MAX_WAIT_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  arb_state_e state;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt;
  logic dma_due, burst_full;
  assign dma_due    = dma_req & (wait_cnt == WW'(MAX_WAIT));
  assign burst_full = cpu_req & (burst_cnt == BW'(MAX_BURST));
  // grants are suppressed while reset is held so no access slips through mid-reset
  assign cpu_gnt   = ~rst & cpu_req & (state == S_CPU ? ~dma_due : ~(dma_req & ~burst_full));
  assign dma_gnt   = ~rst & dma_req & (state == S_CPU ? ~cpu_gnt : ~burst_full);
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign mem_read  = dma_gnt ? ~dma_we : cpu_gnt & ~cpu_we;
  assign mem_write = dma_gnt ? dma_we : cpu_gnt & cpu_we;
  assign mem_addr  = dma_gnt ? dma_addr : cpu_addr;
  assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_CPU;
      wait_cnt   <= '0;
      burst_cnt  <= '0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      wait_cnt   <= (dma_gnt | ~dma_req) ? '0 : wait_cnt + WW'(wait_cnt != WW'(MAX_WAIT));
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dma_rvalid <= dma_gnt & ~dma_we;
      if (cpu_gnt & ~cpu_we) cpu_rdata <= mem_rdata;
      if (dma_gnt & ~dma_we) dma_rdata <= mem_rdata;
      if (state == S_CPU) begin
        if (dma_gnt & dma_lock) begin
          state     <= S_DMA;
          burst_cnt <= BW'(1);
        end
      end else if ((dma_gnt & ~dma_lock) | ~dma_req | cpu_gnt) begin
        state     <= S_CPU;
        burst_cnt <= '0;
      end else if (dma_gnt && burst_cnt != BW'(MAX_BURST)) begin
        burst_cnt <= burst_cnt + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed arbiter checks with a memory model and a read-response scoreboard
module tb_dmem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0, dma_lock = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_read, mem_write;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] cpu_q[$], dma_q[$];
  int n_assert = 0, n_fail = 0;
  string pat;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic resp();
    chk1("cpu_rvalid", cpu_rvalid, cpu_q.size() != 0);
    if (cpu_q.size() != 0) chk32("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    chk1("dma_rvalid", dma_rvalid, dma_q.size() != 0);
    if (dma_q.size() != 0) chk32("dma_rdata", dma_rdata, dma_q.pop_front());
  endtask

  task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dw, input logic dl, input logic [31:0] da,
                      input logic [31:0] dd, input logic ec, input logic ed);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
    #3;
    chk1("cpu_gnt", cpu_gnt, ec);
    chk1("dma_gnt", dma_gnt, ed);
    chk1("cpu_stall", cpu_stall, cr & ~ec);
    chk1("mem_read", mem_read, (ec & ~cw) | (ed & ~dw));
    chk1("mem_write", mem_write, (ec & cw) | (ed & dw));
    if (ec | ed) chk32("mem_addr", mem_addr, ed ? da : ca);
    if ((ec & cw) | (ed & dw)) chk32("mem_wdata", mem_wdata, ed ? dd : cd);
    if (ec) begin
      if (cw) ref_mem[ca[9:2]] = cd;
      else cpu_q.push_back(ref_mem[ca[9:2]]);
    end
    if (ed) begin
      if (dw) ref_mem[da[9:2]] = dd;
      else dma_q.push_back(ref_mem[da[9:2]]);
    end
    @(posedge clk);
    #1;
    resp();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem[k] = 32'h0101_0101 * k;
      ref_mem[k] = 32'h0101_0101 * k;
    end
    mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
    mem[5] = 32'h1111_1111; ref_mem[5] = 32'h1111_1111;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("rst_dma_rvalid", dma_rvalid, 1'b0);
    chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk32("rst_dma_rdata", dma_rdata, 32'h0);
    chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0);
    pat = "CCCCDC";
    for (int i = 0; i < pat.len(); i++)
      step(1, 0, 32'h10, 0, 1, 0, 0, 32'h14, 0, pat[i] == "C", pat[i] == "D");
    step(0, 0, 0, 0, 1, 1, 0, 32'h20, 32'h42, 0, 1);
    step(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0);
    pat = "CCCCDDDDDDDDCCCCD";
    for (int i = 0; i < pat.len(); i++)
      step(1, 0, 32'h10, 0, 1, 0, i < pat.len() - 1, 32'h14, 0, pat[i] == "C", pat[i] == "D");
    step(0, 0, 0, 0, 1, 0, 1, 32'h14, 0, 0, 1);
    step(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 1, 32'h14, 0, 0, 1);
    cpu_req = 0; dma_req = 1; dma_we = 0; dma_lock = 1; dma_addr = 32'h14;
    #3;
    chk1("burst_dma_gnt", dma_gnt, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rst_dma_gnt", dma_gnt, 1'b0);
    chk1("rst_mem_read", mem_read, 1'b0);
    dma_we = 1'b1;
    #1;
    chk1("rst_mem_write", mem_write, 1'b0);
    @(posedge clk);
    #1;
    chk1("rst_drop_dma_rvalid", dma_rvalid, 1'b0);
    chk1("rst_drop_cpu_rvalid", cpu_rvalid, 1'b0);
    rst = 1'b0;
    pat = "CCCCD";
    for (int i = 0; i < pat.len(); i++)
      step(1, 0, 32'h10, 0, 1, 0, 0, 32'h14, 0, pat[i] == "C", pat[i] == "D");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-ported 1 KB data memory between the pipeline MEM stage (CPU port) and a DMA/program-loader port (DMA port). One access per cycle. CPU has default priority; a starvation counter guarantees DMA progress. A bounded lock lets DMA run short bursts. Read data is returned one cycle after grant through a registered, tagged response path. Emits a stall to the pipeline hazard unit when the CPU request is not granted.

Parameters:
ADDR_W, 32, byte address width of both requesters and memory port
DATA_W, 32, data width
MAX_WAIT, 4, max consecutive cycles a pending DMA request may be denied (>=1)
MAX_BURST, 8, max consecutive DMA grants under dma_lock before CPU gets one slot (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request (MEM stage, held until granted)
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  DATA_W  CPU store data
cpu_gnt  out  1  CPU access performed this cycle (combinational)
cpu_stall  out  1  cpu_req & ~cpu_gnt
cpu_rvalid  out  1  CPU load data valid (registered)
cpu_rdata  out  DATA_W  CPU load data (registered)
dma_req  in  1  DMA access request (held until granted)
dma_we  in  1  1 = write, 0 = read
dma_lock  in  1  request to retain ownership for the next beat
dma_addr  in  ADDR_W  DMA byte address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  DMA access performed this cycle (combinational)
dma_rvalid  out  1  DMA read data valid (registered)
dma_rdata  out  DATA_W  DMA read data (registered)
mem_read  out  1  to memory read enable
mem_write  out  1  to memory write enable
mem_addr  out  ADDR_W  muxed address
mem_wdata  out  DATA_W  muxed write data
mem_rdata  in  DATA_W  combinational read data from memory

Behaviour:
- Reset: state=S_CPU, wait_cnt=0, burst_cnt=0, cpu_rvalid=dma_rvalid=0, cpu_rdata=dma_rdata=0. Combinational outputs deasserted while no request.
- States: S_CPU (CPU preferred), S_DMA (DMA owns a locked burst).
- S_CPU grant: cpu_req & ~(dma_req & wait_cnt==MAX_WAIT) -> CPU; else dma_req -> DMA. At most one grant per cycle.
- wait_cnt: increments (saturating at MAX_WAIT) each cycle dma_req is denied; clears on dma_gnt or ~dma_req.
- S_CPU -> S_DMA when dma_gnt & dma_lock; burst_cnt loads 1.
- S_DMA grant: dma_req -> DMA, unless burst_cnt==MAX_BURST & cpu_req, which grants CPU. If ~dma_req, CPU may be granted in same cycle.
- S_DMA -> S_CPU when ~dma_lock at a DMA grant, ~dma_req, or CPU granted; burst_cnt clears. burst_cnt increments on each DMA grant in S_DMA, saturating at MAX_BURST.
- Memory drive: mem_read = gnt & ~we, mem_write = gnt & we of the granted port; mem_addr/mem_wdata muxed from granted port (CPU when none, read/write low).
- Read response: latency 1. At clock edge after granted load, <port>_rvalid=1 for exactly one cycle, <port>_rdata=mem_rdata sampled at grant. Writes produce no rvalid. rdata holds last value otherwise.
- Store and load same address in consecutive cycles: load sees stored data (memory writes on edge).
- Simultaneous first requests after reset: CPU wins, DMA wait_cnt=1.
- Reset mid-burst: returns to S_CPU immediately, pending rvalid dropped.

Decomposition:
- Package dmem_arb_pkg: state encoding constants (S_CPU, S_DMA), default MAX_WAIT/MAX_BURST, port index constants.
- No sub-module; the response register pair is inline. Top-level instantiates dmem_arbiter between MEM stage, loader and the data memory.

Test Plan:
- Only cpu_req load addr 0x10 with mem word 0xDEADBEEF -> cpu_gnt=1 same cycle, next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, cpu_stall=0.
- cpu_req and dma_req both held continuously, MAX_WAIT=4 -> CPU granted cycles 0-3, DMA granted cycle 4 with cpu_stall=1, wait_cnt back to 0.
- dma_lock held, dma_req continuous, cpu_req continuous, MAX_BURST=8 after DMA takes bus -> 7 further DMA grants then one CPU grant, state S_CPU.
- DMA write 0x00000042 to 0x20, then CPU load 0x20 next cycle -> cpu_rdata=0x00000042.
- rst asserted mid-burst with a read granted -> dma_rvalid=0 next edge, state S_CPU, counters 0. No mem_write after rst asserted.
- No requests -> mem_read=mem_write=0, both gnt=0, no rvalid.
